// File: rtl/dwconv_requant_unit.sv
// Depthwise-conv output stage: adds per-channel bias to int32 accumulators and requantises
// them to int8 (TFLite SRDHM, rounding shift, zero point, clamp) through a 3-stage pipeline.
module dwconv_requant_unit #(
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 8,
    parameter int MAX_CH = 256,
    parameter int CH_AW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CH_AW-1:0] num_channels,
    input  logic [31:0]      total_elems,
    input  logic [31:0]      multiplier,
    input  logic [4:0]       shift,
    input  logic [OUT_W-1:0] out_zp,
    input  logic [OUT_W-1:0] act_min,
    input  logic [OUT_W-1:0] act_max,
    input  logic             bias_we,
    input  logic [CH_AW-1:0] bias_addr,
    input  logic [ACC_W-1:0] bias_data,
    input  logic             in_valid,
    input  logic [ACC_W-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
    output logic             ready,
    output logic             done,
    output logic [1:0]       dbg_state
);

    // Handshake: a beat transfers on a cycle where valid and ready are both high at the
    // clock edge; valid never waits on ready, and a held valid keeps its data stable.
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic signed [63:0] POS_NUDGE = 64'sd1073741824;
    localparam logic signed [63:0] NEG_NUDGE = -64'sd1073741823;

    state_t state_q, state_d;

    logic [ACC_W-1:0] bias_mem [MAX_CH];
    logic [31:0]      total_r, mult_r, in_cnt, out_cnt;
    logic [4:0]       shift_r;
    logic [OUT_W-1:0] zp_r, min_r, max_r;
    logic [CH_AW-1:0] ch, ch_last;
    logic             v1, v2;
    logic [31:0]      s1, s2;
    logic             en, in_fire, out_fire;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {a[31], a} + {b[31], b};
        if (sum[32] != sum[31])
            return sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return sum[31:0];
    endfunction

    function automatic logic [31:0] srdhm(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p, sum;
        if (a == 32'h8000_0000 && b == 32'h8000_0000)
            return 32'h7FFF_FFFF;
        p   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        sum = p + (p[63] ? NEG_NUDGE : POS_NUDGE);
        // Bias negative sums so the arithmetic shift truncates toward zero.
        if (sum[63])
            sum = sum + 64'sd2147483647;
        sum = sum >>> 31;
        return sum[31:0];
    endfunction

    function automatic logic [OUT_W-1:0] requant(input logic [31:0] x, input logic [4:0] sh,
                                                 input logic [OUT_W-1:0] zp,
                                                 input logic [OUT_W-1:0] lo_v,
                                                 input logic [OUT_W-1:0] hi_v);
        logic [31:0]        mask, r, th;
        logic signed [31:0] y;
        logic signed [33:0] z, lo, hi;
        mask = (32'd1 << sh) - 32'd1;
        r    = x & mask;
        th   = (mask >> 1) + {31'd0, x[31]};
        y    = ($signed(x) >>> sh) + ((r > th) ? 32'sd1 : 32'sd0);
        z    = $signed({{2{y[31]}}, y}) + $signed({{(34-OUT_W){zp[OUT_W-1]}}, zp});
        lo   = $signed({{(34-OUT_W){lo_v[OUT_W-1]}}, lo_v});
        hi   = $signed({{(34-OUT_W){hi_v[OUT_W-1]}}, hi_v});
        if (z < lo)
            z = lo;
        else if (z > hi)
            z = hi;
        return z[OUT_W-1:0];
    endfunction

    assign en        = !out_valid || out_ready;
    assign in_ready  = (state_q == RUN) && en && (in_cnt < total_r);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign ready     = (state_q == IDLE);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (total_elems == 32'd0) ? DONE : RUN;
            RUN:     if (in_fire && in_cnt == total_r - 32'd1) state_d = DRAIN;
            DRAIN:   if (out_fire && out_cnt == total_r - 32'd1) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // The table is writable only between tensors and is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (bias_we && state_q == IDLE)
            bias_mem[bias_addr] <= bias_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            total_r   <= '0;
            mult_r    <= '0;
            shift_r   <= '0;
            zp_r      <= '0;
            min_r     <= '0;
            max_r     <= '0;
            ch_last   <= '0;
            ch        <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            s1        <= '0;
            s2        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                total_r <= total_elems;
                mult_r  <= multiplier;
                shift_r <= shift;
                zp_r    <= out_zp;
                min_r   <= act_min;
                max_r   <= act_max;
                ch_last <= (num_channels == '0) ? '0 : num_channels - 1'b1;
                ch      <= '0;
                in_cnt  <= '0;
                out_cnt <= '0;
            end
            if (in_fire) begin
                in_cnt <= in_cnt + 32'd1;
                ch     <= (ch == ch_last) ? '0 : ch + 1'b1;
            end
            if (out_fire)
                out_cnt <= out_cnt + 32'd1;
            if (en) begin
                v1        <= in_fire;
                s1        <= sat_add(in_data, bias_mem[ch]);
                v2        <= v1;
                s2        <= srdhm(s1, mult_r);
                out_valid <= v2;
                if (v2)
                    out_data <= requant(s2, shift_r, zp_r, min_r, max_r);
            end
        end
    end

endmodule
